// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache for the moxie core.
// Big-endian byte lanes: byte offset 0 lives in bits 31:24 and maps to wb_sel_o[3].
// Optional build macro: DCACHE_INVALIDATE_EN adds inv_i, a whole-cache invalidate taken in IDLE.
module dcache_dm #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NUM_LINES  = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [31:0]       data_i,
    input  logic              we_i,
    input  logic [1:0]        sel_i,
    output logic [31:0]       data_o,
    output logic              ack_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
`ifdef DCACHE_INVALIDATE_EN
    input  logic              inv_i,
`endif
    input  logic              wb_ack_i
);

    localparam int unsigned WRD_W     = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W     = WRD_W + 2;
    localparam int unsigned IDX_W     = $clog2(NUM_LINES);
    localparam int unsigned TAG_W     = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned CNT_W     = (WRD_W > 0) ? WRD_W : 1;
    localparam int unsigned FLAT_W    = IDX_W + WRD_W;
    localparam int unsigned NUM_WORDS = NUM_LINES * LINE_WORDS;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_WRITE,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdat_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic [CNT_W-1:0]    word_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]    tag_mem_q  [NUM_LINES];
    logic [31:0]         data_mem_q [NUM_WORDS];

    logic [ADDR_W-1:0]   addr_al;
    logic [1:0]          size_in;
    logic                inv_req;
    logic                accept;
    logic                inv_clr;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [1:0]          boff;
    logic                hit;
    logic [31:0]         cur_word;
    logic [31:0]         word_shift;
    logic [31:0]         load_data;
    logic [3:0]          lanes;
    logic [31:0]         lane_mask;
    logic [31:0]         bus_wdat;
    logic [31:0]         merged;
    logic                refill_beat;
    logic                refill_last;
    logic                store_hit;
    logic                load_miss;

`ifdef DCACHE_INVALIDATE_EN
    assign inv_req = inv_i;
`else
    assign inv_req = 1'b0;
`endif

    function automatic logic [FLAT_W-1:0] flat(input logic [IDX_W-1:0] i, input logic [CNT_W-1:0] w);
        return (FLAT_W'(i) << WRD_W) | FLAT_W'(w);
    endfunction

    // Force low address bits to the access size and normalise size 00 to word
    always_comb begin
        addr_al = address_i;
        case (sel_i)
            2'b01:   addr_al = address_i;
            2'b10:   addr_al[0] = 1'b0;
            default: addr_al[1:0] = 2'b00;
        endcase
        size_in = (sel_i == 2'b00) ? 2'b11 : sel_i;
    end

    assign accept  = (state_q == S_IDLE) && req_i && !inv_req;
    assign inv_clr = (state_q == S_IDLE) && inv_req;

    assign idx      = addr_q[OFF_W +: IDX_W];
    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign boff     = addr_q[1:0];
    assign hit      = valid_q[idx] && (tag_mem_q[idx] == tag);
    assign cur_word = data_mem_q[flat(idx, word_q)];

    // Big-endian lane selection, lane replication and load extraction
    always_comb begin
        case (size_q)
            2'b01:   lanes = 4'b1000 >> boff;
            2'b10:   lanes = boff[1] ? 4'b0011 : 4'b1100;
            default: lanes = 4'b1111;
        endcase
        lane_mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
        case (size_q)
            2'b01:   bus_wdat = {4{wdat_q[7:0]}} & lane_mask;
            2'b10:   bus_wdat = {2{wdat_q[15:0]}} & lane_mask;
            default: bus_wdat = wdat_q;
        endcase
        merged     = (cur_word & ~lane_mask) | bus_wdat;
        word_shift = cur_word >> {~boff, 3'b000};
        case (size_q)
            2'b01:   load_data = {24'b0, word_shift[7:0]};
            2'b10:   load_data = boff[1] ? {16'b0, cur_word[15:0]} : {16'b0, cur_word[31:16]};
            default: load_data = cur_word;
        endcase
    end

    assign refill_beat = (state_q == S_REFILL) && wb_ack_i;
    assign refill_last = refill_beat && (cnt_q == LAST_WORD);
    assign store_hit   = (state_q == S_LOOKUP) && we_q && hit;
    assign load_miss   = (state_q == S_LOOKUP) && !we_q && !hit;

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        stall_o  = 1'b0;
        ack_o    = 1'b0;
        data_o   = '0;
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_sel_o = '0;
        wb_we_o  = 1'b0;
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (inv_req) begin
                    stall_o = 1'b1;
                end else if (req_i) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                stall_o = 1'b1;
                if (we_q) begin
                    state_d = S_WRITE;
                end else if (hit) begin
                    ack_o   = 1'b1;
                    data_o  = load_data;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                stall_o  = 1'b1;
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_sel_o = 4'b1111;
                wb_adr_o = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} + (ADDR_W'(cnt_q) << 2);
                if (refill_last) begin
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                stall_o  = 1'b1;
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_sel_o = lanes;
                wb_dat_o = bus_wdat;
                wb_adr_o = {addr_q[ADDR_W-1:2], 2'b00};
                if (wb_ack_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                stall_o = 1'b1;
                ack_o   = 1'b1;
                data_o  = we_q ? 32'h0 : load_data;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, request latch, refill counter and valid bits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b11;
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= addr_al;
                wdat_q <= data_i;
                we_q   <= we_i;
                size_q <= size_in;
                word_q <= CNT_W'((addr_al >> 2) & ADDR_W'(LINE_WORDS - 1));
            end
            if (state_q == S_LOOKUP) begin
                cnt_q <= '0;
            end else if (refill_beat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // A line being refilled is invalid until its last word lands
            if (inv_clr) begin
                valid_q <= '0;
            end else if (load_miss) begin
                valid_q[idx] <= 1'b0;
            end else if (refill_last) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage (no reset; qualified by valid bits)
    always_ff @(posedge clk_i) begin
        if (refill_beat) begin
            data_mem_q[flat(idx, cnt_q)] <= wb_dat_i;
        end else if (store_hit) begin
            data_mem_q[flat(idx, word_q)] <= merged;
        end
        if (refill_last) begin
            tag_mem_q[idx] <= tag;
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed plus randomized checks of dcache_dm against a line-level cache model.
// Build with DCACHE_INVALIDATE_EN defined to include the invalidate step.
module tb_dcache_dm;

    localparam int unsigned NL = 64;
    localparam int unsigned LW = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] address_i;
    logic [31:0] data_i;
    logic        we_i;
    logic [1:0]  sel_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        stall_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
`ifdef DCACHE_INVALIDATE_EN
    logic        inv_i;
`endif

    dcache_dm #(.ADDR_W(32), .NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .address_i(address_i),
        .data_i(data_i), .we_i(we_i), .sel_i(sel_i), .data_o(data_o),
        .ack_o(ack_o), .stall_o(stall_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
`ifdef DCACHE_INVALIDATE_EN
        .inv_i(inv_i),
`endif
        .wb_ack_i(wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // ---------------- bus memory (slave side) ----------------
    logic [31:0] bus_mem [4096];
    logic        bus_w   [4096];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          wait_q = 0;
    logic [31:0] rd_adr_q [$];
    logic [31:0] last_w_adr, last_w_dat;
    logic [3:0]  last_w_sel;

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return (bus_w[a[13:2]] === 1'b1) ? bus_mem[a[13:2]] : {a[15:0], 16'hC0DE};
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (s[l]) r[8*l +: 8] = d[8*l +: 8];
        return r;
    endfunction

    // Wishbone slave with random wait states; registered one-cycle ack
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_ack_i <= 1'b0;
            wait_q   <= 0;
        end else if (wb_ack_i) begin
            wb_ack_i <= 1'b0;
        end else if (wb_cyc_o && wb_stb_o) begin
            if (wait_q != 0) begin
                wait_q <= wait_q - 1;
            end else begin
                wb_ack_i <= 1'b1;
                wait_q   <= int'($urandom_range(0, 2));
                if (wb_we_o) begin
                    wr_cnt     <= wr_cnt + 1;
                    last_w_adr <= wb_adr_o;
                    last_w_dat <= wb_dat_o;
                    last_w_sel <= wb_sel_o;
                    bus_mem[wb_adr_o[13:2]] <= lane_merge(bus_rd(wb_adr_o), wb_dat_o, wb_sel_o);
                    bus_w[wb_adr_o[13:2]]   <= 1'b1;
                end else begin
                    rd_cnt   <= rd_cnt + 1;
                    rd_adr_q.push_back(wb_adr_o);
                    wb_dat_i <= bus_rd(wb_adr_o);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [4096];
    bit          ref_w   [4096];
    bit          m_valid [NL];
    logic [31:0] m_line  [NL];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_w[a[13:2]] ? ref_mem[a[13:2]] : {a[15:0], 16'hC0DE};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic access(input logic we, input logic [1:0] sel, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdata, output int lat,
                          output logic ok);
        int n;
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; sel_i = sel; address_i = a; data_i = d;
        @(negedge clk_i);
        req_i = 1'b0;
        n = 1;
        while (ack_o !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        ok    = (ack_o === 1'b1);
        rdata = data_o;
        lat   = n;
        @(negedge clk_i);
        chk("ack_one_cycle", 32'(ack_o), 32'd0);
    endtask

    // One access, checked against the model from the cache's observable rules
    task automatic run(input logic we, input logic [1:0] sel, input logic [31:0] a,
                       input logic [31:0] d, input string tag, output logic [31:0] rdata);
        int          sz, off, li, lat, r0, w0, sh;
        logic [31:0] al, wa, lb, w, exp_d, exp_dat;
        logic [3:0]  exp_sel;
        logic        hit, ok;
        sz  = (sel == 2'b00) ? 3 : int'(sel);
        al  = (sz == 1) ? a : (sz == 2) ? (a & ~32'd1) : (a & ~32'd3);
        off = int'(al % 4);
        wa  = al & ~32'd3;
        lb  = al / 16;
        li  = int'(lb % NL);
        hit = m_valid[li] && (m_line[li] == lb);
        r0 = rd_cnt; w0 = wr_cnt;
        access(we, sel, a, d, rdata, lat, ok);
        chk({tag, "/ack"}, 32'(ok), 32'd1);
        if (!we) begin
            w = ref_rd(wa);
            if (sz == 1)      exp_d = (w >> (8 * (3 - off))) % 256;
            else if (sz == 2) exp_d = (w >> (8 * (2 - off))) % 65536;
            else              exp_d = w;
            chk({tag, "/data"}, rdata, exp_d);
            chk({tag, "/reads"}, 32'(rd_cnt - r0), hit ? 32'd0 : 32'(LW));
            chk({tag, "/writes"}, 32'(wr_cnt - w0), 32'd0);
            if (hit) chk({tag, "/hit_lat"}, 32'(lat), 32'd1);
            else begin
                for (int k = 0; k < LW; k++)
                    if (rd_adr_q.size() >= LW)
                        chk({tag, "/refill_adr"}, rd_adr_q[rd_adr_q.size() - LW + k],
                            lb * 16 + 32'(4 * k));
                m_valid[li] = 1'b1;
                m_line[li]  = lb;
            end
        end else begin
            if (sz == 1)      begin exp_sel = 4'(1 << (3 - off)); sh = 8 * (3 - off); exp_dat = (d % 256) << sh; end
            else if (sz == 2) begin exp_sel = (off == 0) ? 4'hC : 4'h3; sh = 8 * (2 - off); exp_dat = (d % 65536) << sh; end
            else              begin exp_sel = 4'hF; exp_dat = d; end
            chk({tag, "/writes"}, 32'(wr_cnt - w0), 32'd1);
            chk({tag, "/reads"}, 32'(rd_cnt - r0), 32'd0);
            chk({tag, "/wsel"}, 32'(last_w_sel), 32'(exp_sel));
            chk({tag, "/wdat"}, last_w_dat, exp_dat);
            chk({tag, "/wadr"}, last_w_adr, wa);
            ref_mem[wa[13:2]] = lane_merge(ref_rd(wa), exp_dat, exp_sel);
            ref_w[wa[13:2]]   = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          r0, n;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; sel_i = 2'b11; address_i = '0; data_i = '0;
`ifdef DCACHE_INVALIDATE_EN
        inv_i = 1'b0;
`endif
        model_clear();
        repeat (2) @(negedge clk_i);
        chk("rst/stall", 32'(stall_o), 0);
        chk("rst/ack", 32'(ack_o), 0);
        chk("rst/data", data_o, 0);
        chk("rst/cyc", 32'(wb_cyc_o), 0);
        chk("rst/stb", 32'(wb_stb_o), 0);
        chk("rst/we", 32'(wb_we_o), 0);
        chk("rst/sel", 32'(wb_sel_o), 0);
        chk("rst/adr", wb_adr_o, 0);
        chk("rst/dat", wb_dat_o, 0);
        rst_i = 1'b0;

        run(1'b0, 2'b11, 32'h100, 0, "t1_load100", rd);
        chk("t1/data_const", rd, 32'h0100C0DE);
        run(1'b0, 2'b11, 32'h108, 0, "t2_load108", rd);
        chk("t2/data_const", rd, 32'h0108C0DE);
        run(1'b0, 2'b01, 32'h109, 0, "t2_byte109", rd);
        chk("t2b/data_const", rd, 32'h00000008);
        run(1'b1, 2'b01, 32'h102, 32'hAB, "t3_store", rd);
        chk("t3/wsel_const", 32'(last_w_sel), 32'h2);
        chk("t3/wdat_const", last_w_dat, 32'h0000AB00);
        run(1'b0, 2'b11, 32'h100, 0, "t3_reload", rd);
        chk("t3/data_const", rd, 32'h0100ABDE);
        run(1'b0, 2'b11, 32'h500, 0, "t4_load500", rd);
        chk("t4/data_const", rd, 32'h0500C0DE);
        r0 = rd_cnt;
        run(1'b0, 2'b11, 32'h100, 0, "t4_remiss", rd);
        chk("t4/remiss_reads", 32'(rd_cnt - r0), 32'd4);

        // Reset in the middle of a refill
        r0 = rd_cnt;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; sel_i = 2'b11; address_i = 32'h200;
        @(negedge clk_i);
        req_i = 1'b0;
        n = 0;
        while (rd_cnt - r0 < 2 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("t5/two_acks", 32'(rd_cnt - r0), 32'd2);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("t5/cyc_drop", 32'(wb_cyc_o), 0);
        chk("t5/stb_drop", 32'(wb_stb_o), 0);
        chk("t5/stall_drop", 32'(stall_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_clear();
        r0 = rd_cnt;
        run(1'b0, 2'b11, 32'h200, 0, "t5_reload", rd);
        chk("t5/reload_reads", 32'(rd_cnt - r0), 32'd4);

`ifdef DCACHE_INVALIDATE_EN
        @(negedge clk_i);
        inv_i = 1'b1;
        #1;
        chk("t6/inv_stall", 32'(stall_o), 1);
        @(negedge clk_i);
        inv_i = 1'b0;
        model_clear();
        r0 = rd_cnt;
        run(1'b0, 2'b11, 32'h200, 0, "t6_after_inv", rd);
        chk("t6/inv_reads", 32'(rd_cnt - r0), 32'd4);
`endif

        // Randomized mix over a few aliasing lines
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
              | 32'($urandom_range(0, 15));
            run(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), a, $urandom, "rand", rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
